// File: rtl/cdc_hs_pkg.sv
// Shared types for the 4-phase REQ/ACK bus-synchronisation transmitter.
package cdc_hs_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } hs_state_t;

   // Block is busy while a handshake is in progress or a word waits in the holding register.
   function automatic logic hs_busy(input hs_state_t state, input logic hold_full);
      return (state != IDLE) || hold_full;
   endfunction

endpackage

// File: rtl/cdc_hs_tx_if.sv
// Local stream plus remote REQ/ACK bus of the handshake transmitter.
interface cdc_hs_tx_if #(
   parameter int unsigned DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              req_out;
   logic [DATA_W-1:0] data_out;
   logic              ack_in;
   logic              done;
   logic              busy;

   modport master (
      input  in_valid, in_data, ack_in,
      output in_ready, req_out, data_out, done, busy
   );

   modport slave (
      output in_valid, in_data, ack_in,
      input  in_ready, req_out, data_out, done, busy
   );
endinterface

// File: rtl/sync_doble_ff.sv
// Two-flop level synchroniser for signals arriving from another clock domain.
module sync_doble_ff #(
   parameter int unsigned DATA_W = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);
   logic [DATA_W-1:0] meta_q;
   logic [DATA_W-1:0] sync_q;

   // First stage may go metastable; only the second stage is used downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/cdc_hs_tx.sv
// Source-domain side of a 4-phase REQ/ACK crossing: holds one local word and
// presents it on a stable bus framed by a level request until the remote acknowledges.
module cdc_hs_tx
   import cdc_hs_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   cdc_hs_tx_if.master bus
);
   logic              ack_s;
   logic              accept_s;
   hs_state_t         state_q;
   logic              hold_full_q;
   logic [DATA_W-1:0] hold_data_q;
   logic [DATA_W-1:0] data_q;
   logic              req_q;
   logic              done_q;

   sync_doble_ff #(.DATA_W(1)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus.ack_in),
      .q_o   (ack_s)
   );

   // Accept needs an empty holder and launch needs a full one, so they never collide.
   assign accept_s = bus.in_valid && !hold_full_q;

   // Handshake FSM with holding register and registered bus outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         data_q      <= '0;
         req_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept_s) begin
            hold_data_q <= bus.in_data;
            hold_full_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               // A stale high ack (remote not yet reset) must block the launch.
               if (hold_full_q && !ack_s) begin
                  data_q      <= hold_data_q;
                  req_q       <= 1'b1;
                  hold_full_q <= 1'b0;
                  state_q     <= REQ;
               end
            end
            REQ: begin
               if (ack_s) begin
                  req_q   <= 1'b0;
                  state_q <= DROP;
               end
            end
            DROP: begin
               if (!ack_s) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready = !hold_full_q;
   assign bus.busy     = hs_busy(state_q, hold_full_q);
   assign bus.req_out  = req_q;
   assign bus.data_out = data_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed and randomized bench for cdc_hs_tx with a word-order scoreboard and remote responder.
module tb_cdc_hs_tx;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cdc_hs_tx_if #(.DATA_W(DW)) bus ();

   cdc_hs_tx #(.DATA_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int launch_cnt = 0;
   logic [DW-1:0] exp_q[$];

   logic resp_auto = 1'b1;
   logic resp_ack = 1'b0;
   logic man_ack = 1'b0;
   int   rise_dly = 3;
   int   fall_dly = 3;
   int   resp_cnt = 0;

   logic          req_prev = 1'b0;
   logic          done_prev = 1'b0;
   logic [DW-1:0] data_prev = '0;

   assign bus.ack_in = resp_auto ? resp_ack : man_ack;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_req(input logic lvl, input int budget, input string tag);
      int n = 0;
      while (bus.req_out !== lvl && n < budget) begin
         tick();
         n++;
      end
      chk(tag, bus.req_out, lvl);
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (bus.done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, bus.done, 1'b1);
   endtask

   task automatic offer_one(input logic [DW-1:0] w);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   // Remote receiver model: raise ack some cycles after req, drop it some cycles after req falls.
   initial begin
      forever begin
         @(negedge clk);
         if (!resp_auto || !rst_n) begin
            resp_ack = 1'b0;
            resp_cnt = 0;
         end else if (bus.req_out && !resp_ack) begin
            if (resp_cnt >= rise_dly) begin
               resp_ack = 1'b1;
               resp_cnt = 0;
            end else resp_cnt++;
         end else if (!bus.req_out && resp_ack) begin
            if (resp_cnt >= fall_dly) begin
               resp_ack = 1'b0;
               resp_cnt = 0;
            end else resp_cnt++;
         end else resp_cnt = 0;
      end
   end

   // Scoreboard: words leave in acceptance order, and the bus only moves on a launch.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            req_prev  = 1'b0;
            done_prev = 1'b0;
            data_prev = '0;
         end else begin
            if (bus.req_out && !req_prev) begin
               launch_cnt++;
               if (exp_q.size() == 0) chk("launch_unexpected", 64'd1, 64'd0);
               else chk("launch_data", bus.data_out, exp_q.pop_front());
            end else begin
               chk("data_stable", bus.data_out, data_prev);
            end
            if (bus.done) begin
               done_cnt++;
               chk("done_one_cycle", done_prev, 1'b0);
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
            req_prev  = bus.req_out;
            done_prev = bus.done;
            data_prev = bus.data_out;
         end
      end
   end

   initial begin
      int d0;
      int l0;
      int n;
      logic [DW-1:0] w;

      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      tick(2);
      chk("rst_req", bus.req_out, 1'b0);
      chk("rst_data", bus.data_out, 32'h0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_ready", bus.in_ready, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      rst_n = 1'b1;
      tick(2);

      // Single word with a well-behaved responder.
      d0 = done_cnt;
      offer_one(32'hA5A5_0001);
      chk("t1_ready_after_accept", bus.in_ready, 1'b0);
      chk("t1_req_not_yet", bus.req_out, 1'b0);
      chk("t1_busy", bus.busy, 1'b1);
      tick();
      chk("t1_req_high", bus.req_out, 1'b1);
      chk("t1_data", bus.data_out, 32'hA5A5_0001);
      wait_done(50, "t1_done");
      chk("t1_data_at_done", bus.data_out, 32'hA5A5_0001);
      tick(5);
      chk("t1_done_count", done_cnt - d0, 64'd1);
      chk("t1_idle", bus.busy, 1'b0);

      // Back-to-back words: second one waits in the holder until the first completes.
      d0 = done_cnt;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h1;
      tick();
      chk("t2_ready_w1", bus.in_ready, 1'b0);
      bus.in_data = 32'h2;
      tick();
      chk("t2_req_w1", bus.req_out, 1'b1);
      chk("t2_data_w1", bus.data_out, 32'h1);
      chk("t2_ready_free", bus.in_ready, 1'b1);
      tick();
      chk("t2_ready_w2", bus.in_ready, 1'b0);
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.done !== 1'b1 && n < 50) begin
         chk("t2_ready_held", bus.in_ready, 1'b0);
         chk("t2_data_hold_w1", bus.data_out, 32'h1);
         tick();
         n++;
      end
      chk("t2_done1", bus.done, 1'b1);
      chk("t2_data_at_done1", bus.data_out, 32'h1);
      tick();
      chk("t2_req_w2", bus.req_out, 1'b1);
      chk("t2_data_w2", bus.data_out, 32'h2);
      chk("t2_ready_after_w2", bus.in_ready, 1'b1);
      wait_done(50, "t2_done2");
      tick(5);
      chk("t2_done_count", done_cnt - d0, 64'd2);

      // Stale ack at reset release blocks the launch until it falls.
      resp_auto = 1'b0;
      man_ack   = 1'b1;
      rst_n     = 1'b0;
      exp_q.delete();
      tick(2);
      rst_n = 1'b1;
      tick(3);
      d0 = done_cnt;
      offer_one(32'h0000_0C03);
      chk("t3_ready_after_accept", bus.in_ready, 1'b0);
      chk("t3_req_blocked", bus.req_out, 1'b0);
      repeat (5) begin
         tick();
         chk("t3_req_blocked", bus.req_out, 1'b0);
         chk("t3_ready_held", bus.in_ready, 1'b0);
      end
      man_ack = 1'b0;
      tick();
      chk("t3_req_edge1", bus.req_out, 1'b0);
      tick();
      chk("t3_req_edge2", bus.req_out, 1'b0);
      tick();
      chk("t3_req_edge3", bus.req_out, 1'b1);
      chk("t3_data", bus.data_out, 32'h0000_0C03);
      man_ack = 1'b1;
      wait_req(1'b0, 10, "t3_req_fall");
      man_ack = 1'b0;
      wait_done(10, "t3_done");
      tick(3);
      chk("t3_done_count", done_cnt - d0, 64'd1);

      // Reset while a word is in flight and another is held.
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEAD_0004;
      tick();
      bus.in_data = 32'hBEEF_0005;
      tick();
      tick();
      bus.in_valid = 1'b0;
      chk("t4_req_inflight", bus.req_out, 1'b1);
      chk("t4_busy_inflight", bus.busy, 1'b1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("t4_req_async", bus.req_out, 1'b0);
      chk("t4_data_async", bus.data_out, 32'h0);
      chk("t4_done_async", bus.done, 1'b0);
      chk("t4_ready_async", bus.in_ready, 1'b1);
      chk("t4_busy_async", bus.busy, 1'b0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("t4_no_relaunch", bus.req_out, 1'b0);
      resp_auto = 1'b1;
      d0 = done_cnt;
      offer_one(32'h1234_5678);
      wait_req(1'b1, 10, "t4_fresh_req");
      chk("t4_fresh_data", bus.data_out, 32'h1234_5678);
      wait_done(50, "t4_fresh_done");
      tick(3);
      chk("t4_done_count", done_cnt - d0, 64'd1);

      // Remote withholds ack for a long time.
      resp_auto = 1'b0;
      man_ack   = 1'b0;
      d0 = done_cnt;
      offer_one(32'hCAFE_0006);
      wait_req(1'b1, 10, "t5_req");
      repeat (200) begin
         tick();
         chk("t5_req_hold", bus.req_out, 1'b1);
         chk("t5_data_hold", bus.data_out, 32'hCAFE_0006);
         chk("t5_busy", bus.busy, 1'b1);
         chk("t5_no_done", bus.done, 1'b0);
      end
      man_ack = 1'b1;
      wait_req(1'b0, 10, "t5_req_fall");
      man_ack = 1'b0;
      wait_done(10, "t5_done");
      tick(3);
      chk("t5_done_count", done_cnt - d0, 64'd1);

      // Ack glitches low for one cycle while the request is already withdrawn.
      d0 = done_cnt;
      offer_one(32'h0BAD_0007);
      wait_req(1'b1, 10, "t6_req");
      man_ack = 1'b1;
      wait_req(1'b0, 10, "t6_req_fall");
      man_ack = 1'b0;
      tick();
      man_ack = 1'b1;
      tick(6);
      man_ack = 1'b0;
      repeat (10) begin
         tick();
         chk("t6_no_relaunch", bus.req_out, 1'b0);
      end
      chk("t6_done_count", done_cnt - d0, 64'd1);
      chk("t6_idle", bus.busy, 1'b0);

      // Randomized traffic against the scoreboard.
      resp_auto = 1'b1;
      d0 = done_cnt;
      l0 = launch_cnt;
      for (int i = 0; i < 24; i++) begin
         rise_dly = int'($urandom_range(0, 4));
         fall_dly = int'($urandom_range(0, 4));
         tick(int'($urandom_range(0, 3)));
         w = $urandom;
         bus.in_valid = 1'b1;
         bus.in_data  = w;
         n = 0;
         while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
         end
         chk("rnd_accept", bus.in_ready, 1'b1);
         tick();
         bus.in_valid = 1'b0;
      end
      n = 0;
      while ((bus.busy !== 1'b0 || exp_q.size() != 0 || bus.ack_in !== 1'b0) && n < 500) begin
         tick();
         n++;
      end
      tick(2);
      chk("rnd_drained", bus.busy, 1'b0);
      chk("rnd_queue_empty", exp_q.size(), 64'd0);
      chk("rnd_launch_count", launch_cnt - l0, 64'd24);
      chk("rnd_done_count", done_cnt - d0, 64'd24);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
